// File: rtl/multiply_divide_unit.sv
// HI/LO multiply-divide unit: single-cycle 32x32 multiply, 32-step restoring divide,
// plus MTHI/MTLO register writes. busy feeds the pipeline stall logic.
module multiply_divide_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  operation,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  input  logic        HI_write_enable,
  input  logic        LO_write_enable,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI_output,
  output logic [31:0] LO_output
);

  typedef enum logic [1:0] {IDLE, MULTIPLY, DIVIDE} state_t;

  state_t      state, state_nx;
  logic [31:0] quot, rem, dvsr;
  logic [5:0]  cnt;
  logic        mul_signed, neg_q, neg_r;
  logic        res_wr, zero_done;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] r_sh, diff;
  logic [31:0] res_hi, res_lo;
  logic        op_signed;

  assign op_signed = ~operation[0];
  assign busy      = (state != IDLE);

  // Multiply reuses quot/dvsr as operand holders; sign-extending to 64 bits
  // makes the truncated unsigned product correct for the signed case too.
  assign ext_a = {{32{mul_signed & quot[31]}}, quot};
  assign ext_b = {{32{mul_signed & dvsr[31]}}, dvsr};
  assign prod  = ext_a * ext_b;

  assign r_sh = {rem, quot[31]};
  assign diff = r_sh - {1'b0, dvsr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    res_wr    = 1'b0;
    zero_done = 1'b0;
    res_hi    = prod[63:32];
    res_lo    = prod[31:0];
    case (state)
      IDLE:     if (start) state_nx = operation[1] ? DIVIDE : MULTIPLY;
      MULTIPLY: begin
        state_nx = IDLE;
        res_wr   = 1'b1;
      end
      DIVIDE: begin
        res_hi = neg_r ? -rem  : rem;
        res_lo = neg_q ? -quot : quot;
        if (dvsr == 32'd0) begin
          state_nx  = IDLE;
          zero_done = 1'b1;
        end else if (cnt == 6'd32) begin
          state_nx = IDLE;
          res_wr   = 1'b1;
        end
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot       <= '0;
      rem        <= '0;
      dvsr       <= '0;
      cnt        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      done       <= 1'b0;
      HI_output  <= '0;
      LO_output  <= '0;
    end else begin
      done <= res_wr | zero_done;
      if (state == IDLE && start) begin
        cnt        <= '0;
        rem        <= '0;
        mul_signed <= op_signed;
        neg_q      <= op_signed & (operand_A[31] ^ operand_B[31]);
        neg_r      <= op_signed & operand_A[31];
        // Divide works on magnitudes; multiply keeps the raw operands.
        if (operation[1]) begin
          quot <= (op_signed & operand_A[31]) ? -operand_A : operand_A;
          dvsr <= (op_signed & operand_B[31]) ? -operand_B : operand_B;
        end else begin
          quot <= operand_A;
          dvsr <= operand_B;
        end
      end else if (state == DIVIDE && dvsr != 32'd0 && cnt != 6'd32) begin
        cnt <= cnt + 6'd1;
        if (!diff[32]) begin
          rem  <= diff[31:0];
          quot <= {quot[30:0], 1'b1};
        end else begin
          rem  <= r_sh[31:0];
          quot <= {quot[30:0], 1'b0};
        end
      end

      if (res_wr) begin
        HI_output <= res_hi;
        LO_output <= res_lo;
      end else if (state == IDLE && !start) begin
        if (HI_write_enable) HI_output <= write_data;
        if (LO_write_enable) LO_output <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard bench for multiply_divide_unit: expected HI/LO pushed at issue,
// popped and compared on every done pulse.
module tb_multiply_divide_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  operation = '0;
  logic [31:0] operand_A = '0, operand_B = '0, write_data = '0;
  logic        HI_write_enable = 1'b0, LO_write_enable = 1'b0;
  logic        busy, done;
  logic [31:0] HI_output, LO_output;

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;
  res_t q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int total = 0, passed = 0, done_cnt = 0, issued = 0;

  multiply_divide_unit dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_A(operand_A), .operand_B(operand_B),
    .HI_write_enable(HI_write_enable), .LO_write_enable(LO_write_enable),
    .write_data(write_data), .busy(busy), .done(done),
    .HI_output(HI_output), .LO_output(LO_output)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      done_cnt++;
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_done: done=1 with no outstanding op");
      end else begin
        res_t e;
        e = q.pop_front();
        if (HI_output !== e.hi || LO_output !== e.lo)
          $display("FAIL result: got HI=%h LO=%h expected HI=%h LO=%h",
                   HI_output, LO_output, e.hi, e.lo);
        else passed++;
      end
    end
  end

  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, qq, rr;
    logic [63:0] p;
    r.hi = m_hi;
    r.lo = m_lo;
    case (op)
      2'b00: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'b10: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        qq = sa / sb; rr = sa % sb;
        r.hi = rr[31:0]; r.lo = qq[31:0];
      end
      default: if (b != 0) begin
        r.hi = a % b; r.lo = a / b;
      end
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where busy has dropped.
  // The next op can be issued right then, i.e. in the done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_busy, input bit poke, input bit mt_poke);
    res_t e;
    int n;
    e = model(op, a, b);
    q.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    issued++;
    start = 1'b1; operation = op; operand_A = a; operand_B = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      start = poke && n == 5;
      if (start) begin operation = 2'b00; operand_A = 32'h1234; operand_B = 32'h5678; end
      LO_write_enable = mt_poke && n == 7;
      write_data = 32'h5;
      @(negedge clk);
    end
    start = 1'b0;
    LO_write_enable = 1'b0;
    total++;
    if (n !== exp_busy) $display("FAIL busy_cycles: got %0d expected %0d", n, exp_busy);
    else passed++;
    total++;
    if (done !== 1'b1) $display("FAIL done_pulse: done=%b expected 1 when busy drops", done);
    else passed++;
  endtask

  task automatic mt_write(input bit hi, input bit lo, input logic [31:0] d);
    HI_write_enable = hi; LO_write_enable = lo; write_data = d;
    @(negedge clk);
    HI_write_enable = 1'b0; LO_write_enable = 1'b0;
    if (hi) m_hi = d;
    if (lo) m_lo = d;
    total++;
    if (HI_output !== m_hi || LO_output !== m_lo)
      $display("FAIL mt_write: got HI=%h LO=%h expected HI=%h LO=%h", HI_output, LO_output, m_hi, m_lo);
    else passed++;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || HI_output !== 32'h0 || LO_output !== 32'h0)
      $display("FAIL reset_state: busy=%b done=%b HI=%h LO=%h expected all 0", busy, done, HI_output, LO_output);
    else passed++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1, 0, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 0, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL done_single: done=%b expected 0", done);
    else passed++;
  endtask

  task automatic test_div();
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 1, 0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 33, 0, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd10, 33, 0, 0);
  endtask

  task automatic test_div_zero();
    mt_write(1, 0, 32'h11);
    mt_write(0, 1, 32'h22);
    do_op(2'b11, 32'd100, 32'd0, 1, 0, 0);
    do_op(2'b10, 32'd5, 32'd0, 1, 0, 0);
  endtask

  task automatic test_div_overflow();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 1);
    @(negedge clk);
    total++;
    if (LO_output !== 32'h8000_0000 || HI_output !== 32'h0)
      $display("FAIL div_overflow: got HI=%h LO=%h expected HI=0 LO=80000000", HI_output, LO_output);
    else passed++;
  endtask

  task automatic test_priority();
    mt_write(1, 1, 32'hCAFE_F00D);
    HI_write_enable = 1'b1; LO_write_enable = 1'b1; write_data = 32'hDEAD_BEEF;
    do_op(2'b00, 32'd2, 32'd3, 1, 0, 0);
    HI_write_enable = 1'b0; LO_write_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 2) ? 32'd1 : $urandom;
      do_op(op, a, b, op[1] ? 33 : 1, 0, 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; operation = 2'b10; operand_A = 32'hFFFF_FFF9; operand_B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || HI_output !== 32'h0 || LO_output !== 32'h0)
      $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h expected all 0", busy, done, HI_output, LO_output);
    else passed++;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(2'b11, 32'd9, 32'd4, 33, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_div_overflow();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== issued || q.size() != 0)
      $display("FAIL done_count: pulses=%0d issued=%0d pending=%0d", done_cnt, issued, q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/multiply_divide_unit.md
MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 operation  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operand_A  input  32  rs value: multiplicand or dividend.
REQ-007 operand_B  input  32  rt value: multiplier or divisor.
REQ-008 HI_write_enable  input  1  MTHI request; load write_data into HI.
REQ-009 LO_write_enable  input  1  MTLO request; load write_data into LO.
REQ-010 write_data  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  high while an accepted operation is in progress; feeds decode/fetch stall logic.
REQ-012 done  output  1  one-cycle pulse; high in the first cycle new HI/LO results are visible.
REQ-013 HI_output  output  32  registered HI value.
REQ-014 LO_output  output  32  registered LO value.

Function
REQ-015 FSM states SHALL be IDLE, MULTIPLY, DIVIDE; busy SHALL be 1 exactly when state is not IDLE.
REQ-016 In IDLE, start=1 at rising edge k SHALL capture operation, operand_A and operand_B, and enter MULTIPLY (op 00/01) or DIVIDE (op 10/11).
REQ-017 start while busy SHALL be ignored: no capture and no effect on the running operation.
REQ-018 MULTIPLY: at edge k+1, {HI,LO} SHALL take the 64-bit product (signed for MULT, unsigned for MULTU); state returns to IDLE; done=1 in cycle k+1..k+2.
REQ-019 DIVIDE SHALL use an iterative restoring divider on magnitudes, one quotient bit per edge over edges k+1..k+32; sign correction and the HI/LO write SHALL occur at edge k+33; busy high for 33 cycles; done=1 in the following cycle.
REQ-020 DIV: LO=quotient truncated toward zero; HI=remainder carrying the dividend's sign. DIVU: unsigned quotient and remainder.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Divisor zero (DIV or DIVU): HI and LO SHALL remain unchanged; state returns to IDLE at edge k+1; done=1 in the following cycle.
REQ-023 In IDLE with start=0, HI_write_enable / LO_write_enable SHALL load write_data into HI / LO at the edge; both may be asserted together.
REQ-024 HI_write_enable and LO_write_enable SHALL be ignored while busy=1, and also in IDLE when start=1 (start has priority).
REQ-025 A start accepted in the same cycle done=1 SHALL be legal; the new operation is captured normally.
REQ-026 done SHALL be 0 in every cycle except the single cycle following a result write or a divide-by-zero completion.
REQ-027 HI_output and LO_output SHALL change only on a result write, an MTHI/MTLO write, or reset.

Reset
REQ-028 While reset=1, the block SHALL hold state=IDLE, busy=0, done=0, HI_output=0, LO_output=0, and the divider working registers at 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no partial HI/LO update; after deassertion the first start is accepted normally.

Verification
REQ-030 MULT with A=0xFFFFFFFE (-2), B=3 -> busy high 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
REQ-031 MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV with A=-7 (0xFFFFFFF9), B=2 -> busy for exactly 33 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); a start pulse mid-divide is ignored.
REQ-033 DIVU with A=100, B=0 and HI/LO preloaded via MTHI=0x11, MTLO=0x22 -> HI=0x11, LO=0x22 unchanged; done pulses 2 cycles after start.
REQ-034 DIV 0x80000000 / -1 -> LO=0x80000000, HI=0; then MTLO 0x5 attempted while busy -> ignored.
REQ-035 Reset asserted at divide cycle 10 -> busy=0, HI=LO=0 immediately; a subsequent DIVU 9/4 gives LO=2, HI=1.
